// File: rtl/dca_matrix_lsu_txn_gen_if.sv
// Instruction and transaction handshake bundle for the DCA matrix LSU write-path
// transaction generator.
interface dca_matrix_lsu_txn_gen_if #(
   parameter int unsigned BW_AXI_ADDR = 32,
   parameter int unsigned BW_NUM_M1   = 8
);
   localparam int unsigned TXN_W = BW_AXI_ADDR + 3 + 8 + 2;

   logic                   inst_valid;
   logic                   inst_ready;
   logic [BW_AXI_ADDR-1:0] inst_addr;
   logic [BW_AXI_ADDR-1:0] inst_stride;
   logic [BW_NUM_M1-1:0]   inst_num_row_m1;
   logic [BW_NUM_M1-1:0]   inst_num_col_m1;
   logic                   busy;
   logic                   txn_valid;
   logic                   txn_ready;
   logic [TXN_W-1:0]       txn_info;

   modport master (
      output inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_col_m1,
      input  inst_ready, busy,
      input  txn_valid, txn_info,
      output txn_ready
   );

   modport slave (
      input  inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_col_m1,
      output inst_ready, busy,
      output txn_valid, txn_info,
      input  txn_ready
   );
endinterface

// File: rtl/dca_matrix_lsu_txn_gen.sv
// Walks a matrix row by row and emits AXI INCR burst descriptors that respect the
// maximum burst length and 4 KB boundaries, closing each instruction with a null txn.
module dca_matrix_lsu_txn_gen #(
   parameter int unsigned BW_AXI_ADDR   = 32,
   parameter int unsigned BW_AXI_DATA   = 32,
   parameter int unsigned BW_ELEM       = 32,
   parameter int unsigned BW_NUM_M1     = 8,
   parameter int unsigned MAX_BURST_LEN = 16
) (
   input logic                     clk,
   input logic                     rst,
   dca_matrix_lsu_txn_gen_if.slave bus
);
   localparam int unsigned BNW   = BW_NUM_M1 + 6;
   localparam int unsigned BYTES = BW_AXI_DATA / 8;

   typedef enum logic [1:0] {IDLE, BURST, TERM} state_t;

   state_t                 state, state_nxt;
   logic [BW_AXI_ADDR-1:0] cur_addr, row_base, stride, step;
   logic [BW_NUM_M1-1:0]   row_idx, num_row_m1;
   logic [BNW-1:0]         beats_per_row, rem_beats, inst_beats, inst_cols;
   logic [BNW-1:0]         len, rem_after, win_beats;
   logic [12:0]            win_bytes;
   logic [7:0]             alen;
   logic                   hs, row_done;

   always_comb begin
      inst_cols  = BNW'(bus.inst_num_col_m1) + BNW'(1);
      inst_beats = (inst_cols * BNW'(BW_ELEM) + BNW'(BW_AXI_DATA - 1)) / BNW'(BW_AXI_DATA);

      // Beats left before the current address reaches the next 4 KB page.
      win_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
      win_beats = BNW'(win_bytes / 13'(BYTES));

      len = rem_beats;
      if (len > BNW'(MAX_BURST_LEN)) len = BNW'(MAX_BURST_LEN);
      if (len > win_beats)           len = win_beats;

      alen      = 8'(len - BNW'(1));
      rem_after = rem_beats - len;
      step      = BW_AXI_ADDR'(len) * BW_AXI_ADDR'(BYTES);
      hs        = bus.txn_valid & bus.txn_ready;
      row_done  = (rem_after == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.inst_ready = 1'b0;
      bus.busy       = 1'b1;
      bus.txn_valid  = 1'b0;
      bus.txn_info   = '0;
      case (state)
         IDLE: begin
            bus.inst_ready = 1'b1;
            bus.busy       = 1'b0;
            if (bus.inst_valid) state_nxt = BURST;
         end
         BURST: begin
            bus.txn_valid = 1'b1;
            bus.txn_info  = {1'b0, 1'b0, alen, cur_addr, 3'b000};
            if (hs && row_done && row_idx == num_row_m1) state_nxt = TERM;
         end
         TERM: begin
            bus.txn_valid = 1'b1;
            bus.txn_info  = {1'b1, 1'b1, 8'd0, {(BW_AXI_ADDR + 3){1'b0}}};
            if (hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr      <= '0;
         row_base      <= '0;
         stride        <= '0;
         row_idx       <= '0;
         num_row_m1    <= '0;
         beats_per_row <= '0;
         rem_beats     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.inst_valid) begin
                  cur_addr      <= bus.inst_addr;
                  row_base      <= bus.inst_addr;
                  stride        <= bus.inst_stride;
                  num_row_m1    <= bus.inst_num_row_m1;
                  row_idx       <= '0;
                  beats_per_row <= inst_beats;
                  rem_beats     <= inst_beats;
               end
            end
            BURST: begin
               if (hs) begin
                  if (row_done && row_idx != num_row_m1) begin
                     row_idx   <= row_idx + BW_NUM_M1'(1);
                     row_base  <= row_base + stride;
                     cur_addr  <= row_base + stride;
                     rem_beats <= beats_per_row;
                  end else begin
                     cur_addr  <= cur_addr + step;
                     rem_beats <= rem_after;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dca_matrix_lsu_txn_gen.sv
// Scoreboard bench for dca_matrix_lsu_txn_gen: expected txn words are queued at issue
// time and compared as the DUT hands them off.
module tb_dca_matrix_lsu_txn_gen;
   localparam int unsigned TW = 45;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dca_matrix_lsu_txn_gen_if #(.BW_AXI_ADDR(32), .BW_NUM_M1(8)) bus ();
   dca_matrix_lsu_txn_gen_if #(.BW_AXI_ADDR(32), .BW_NUM_M1(8)) bus8 ();

   dca_matrix_lsu_txn_gen #(
      .BW_AXI_ADDR(32), .BW_AXI_DATA(32), .BW_ELEM(32), .BW_NUM_M1(8), .MAX_BURST_LEN(16)
   ) u_dut (.clk(clk), .rst(rst), .bus(bus));

   dca_matrix_lsu_txn_gen #(
      .BW_AXI_ADDR(32), .BW_AXI_DATA(32), .BW_ELEM(8), .BW_NUM_M1(8), .MAX_BURST_LEN(16)
   ) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [TW-1:0] sb[$];

   int unsigned mode = 0;       // 0: always ready, 1: 5-cycle stall per txn, 2: manual
   logic        manual_ready = 1'b1;
   int unsigned stall_cnt = 0;
   logic        hs_seen = 1'b0;
   logic        stalled_prev = 1'b0;
   logic [TW-1:0] info_prev = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] mk(input logic nul, input logic last,
                                        input logic [7:0] alen, input logic [31:0] addr);
      return {nul, last, alen, addr, 3'b000};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.txn_valid && stalled_prev)
            check("stall_hold", 64'(bus.txn_info), 64'(info_prev));
         if (bus.txn_valid && bus.txn_ready) begin
            if (sb.size() == 0) check("extra_txn", 64'(sb.size()), 64'(1));
            else                check("txn", 64'(bus.txn_info), 64'(sb.pop_front()));
         end
      end
      hs_seen      = bus.txn_valid & bus.txn_ready;
      stalled_prev = bus.txn_valid & ~bus.txn_ready;
      info_prev    = bus.txn_info;
   end

   always @(posedge clk) begin
      #1;
      case (mode)
         0: bus.txn_ready = 1'b1;
         1: begin
            if (hs_seen) begin
               bus.txn_ready = 1'b0;
               stall_cnt     = 1;
            end else if (!bus.txn_valid) begin
               bus.txn_ready = 1'b0;
               stall_cnt     = 0;
            end else if (!bus.txn_ready) begin
               stall_cnt++;
               if (stall_cnt >= 6) bus.txn_ready = 1'b1;
            end
         end
         default: bus.txn_ready = manual_ready;
      endcase
   end

   task automatic issue(input logic [31:0] addr, input logic [31:0] stride,
                        input logic [7:0] rows_m1, input logic [7:0] cols_m1);
      for (int i = 0; i < 100 && !bus.inst_ready; i++) @(negedge clk);
      check("inst_ready_before_issue", 64'(bus.inst_ready), 64'(1));
      @(posedge clk);
      #1;
      bus.inst_addr       = addr;
      bus.inst_stride     = stride;
      bus.inst_num_row_m1 = rows_m1;
      bus.inst_num_col_m1 = cols_m1;
      bus.inst_valid      = 1'b1;
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      @(negedge clk);
      check("first_valid", 64'(bus.txn_valid), 64'(1));
      check("busy_after_accept", 64'(bus.busy), 64'(1));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (sb.size() == 0) break;
      end
      check({tag, "_drain"}, 64'(sb.size()), 64'(0));
      @(negedge clk);
      check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
      check({tag, "_ready_done"}, 64'(bus.inst_ready), 64'(1));
      check({tag, "_valid_done"}, 64'(bus.txn_valid), 64'(0));
   endtask

   task automatic push_basic();
      sb.push_back(mk(1'b0, 1'b0, 8'd3, 32'h1000));
      sb.push_back(mk(1'b0, 1'b0, 8'd3, 32'h1100));
      sb.push_back(mk(1'b1, 1'b1, 8'd0, 32'h0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.inst_valid = 1'b0; bus.inst_addr = '0; bus.inst_stride = '0;
      bus.inst_num_row_m1 = '0; bus.inst_num_col_m1 = '0;
      bus8.inst_valid = 1'b0; bus8.inst_addr = '0; bus8.inst_stride = '0;
      bus8.inst_num_row_m1 = '0; bus8.inst_num_col_m1 = '0; bus8.txn_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_inst_ready", 64'(bus.inst_ready), 64'(1));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_txn_valid", 64'(bus.txn_valid), 64'(0));
      check("rst_txn_info", 64'(bus.txn_info), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      push_basic();
      issue(32'h1000, 32'h100, 8'd1, 8'd3);
      drain("basic");

      sb.push_back(mk(1'b0, 1'b0, 8'd15, 32'h2000));
      sb.push_back(mk(1'b0, 1'b0, 8'd3, 32'h2040));
      sb.push_back(mk(1'b1, 1'b1, 8'd0, 32'h0));
      issue(32'h2000, 32'h0, 8'd0, 8'd19);
      drain("split");

      sb.push_back(mk(1'b0, 1'b0, 8'd1, 32'h0FF8));
      sb.push_back(mk(1'b0, 1'b0, 8'd1, 32'h1000));
      sb.push_back(mk(1'b1, 1'b1, 8'd0, 32'h0));
      issue(32'h0FF8, 32'h0, 8'd0, 8'd3);
      drain("4k");

      mode = 1;
      push_basic();
      issue(32'h1000, 32'h100, 8'd1, 8'd3);
      drain("stall");
      mode = 0;

      // Reset lands while the second burst of the 20-column row is stalled.
      manual_ready = 1'b1;
      @(posedge clk);
      mode = 2;
      sb.push_back(mk(1'b0, 1'b0, 8'd15, 32'h2000));
      issue(32'h2000, 32'h0, 8'd0, 8'd19);
      manual_ready = 1'b0;
      @(posedge clk);
      #2;
      check("mid_burst2", 64'(bus.txn_info), 64'(mk(1'b0, 1'b0, 8'd3, 32'h2040)));
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(bus.txn_valid), 64'(0));
      check("mid_rst_ready", 64'(bus.inst_ready), 64'(1));
      check("mid_rst_busy", 64'(bus.busy), 64'(0));
      check("mid_rst_info", 64'(bus.txn_info), 64'(0));
      check("mid_rst_sb", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      mode = 0;

      push_basic();
      issue(32'h1000, 32'h100, 8'd1, 8'd3);
      drain("post_rst");

      @(posedge clk);
      #1;
      bus8.inst_addr = 32'h3000; bus8.inst_stride = '0;
      bus8.inst_num_row_m1 = 8'd0; bus8.inst_num_col_m1 = 8'd4;
      bus8.inst_valid = 1'b1;
      @(posedge clk);
      #1 bus8.inst_valid = 1'b0;
      @(negedge clk);
      check("packed_valid", 64'(bus8.txn_valid), 64'(1));
      check("packed_burst", 64'(bus8.txn_info), 64'(mk(1'b0, 1'b0, 8'd1, 32'h3000)));
      @(negedge clk);
      check("packed_term", 64'(bus8.txn_info), 64'(mk(1'b1, 1'b1, 8'd0, 32'h0)));
      @(negedge clk);
      check("packed_idle", 64'(bus8.inst_ready), 64'(1));
      check("packed_valid_done", 64'(bus8.txn_valid), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
